// File: rtl/dram_rd_pkg.sv
// Shared types and default geometry for the DRAM burst reader.
package dram_rd_pkg;

    localparam int DEF_ADDR_WIDTH = 24;
    localparam int DEF_MEM_DEPTH  = 2097152;
    localparam int DEF_MEM_WIDTH  = 8;
    localparam int DEF_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } rd_state_e;

endpackage

// File: rtl/dram_rd_fifo.sv
// Synchronous word FIFO between the packer and the consumer; push and pop may coincide.
module dram_rd_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage write; contents need no reset because reads are gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping; pointers wrap on the power-of-2 depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/dram_burst_reader.sv
// Burst read initiator: issues byte addresses to the DRAM under word credits,
// captures returning bytes after the read latency and packs them into words.
module dram_burst_reader
    import dram_rd_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int MEM_WIDTH  = DEF_MEM_WIDTH,
    parameter int WORD_BYTES = DEF_WORD_BYTES,
    parameter int LEN_WIDTH  = 16,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [ADDR_WIDTH-1:0]           req_addr,
    input  logic [LEN_WIDTH-1:0]            req_len,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    input  logic [MEM_WIDTH-1:0]            mem_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [MEM_WIDTH*WORD_BYTES-1:0] out_data,
    output logic [WORD_BYTES-1:0]           out_keep,
    output logic                            out_last,
    output logic                            done
);
    localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W  = CNT_W + 1;
    localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(WORD_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = ADDR_WIDTH'(MEM_DEPTH - 1);

    typedef struct packed {
        logic [WORD_BYTES-1:0][MEM_WIDTH-1:0] data;
        logic [WORD_BYTES-1:0]                keep;
        logic                                 last;
    } word_t;

    rd_state_e state, state_nxt;

    logic [LEN_WIDTH-1:0]  rem, rem_nxt;        // bytes still to issue after the current one
    logic [LANE_W-1:0]     iss_lane;            // lane of the next byte to issue
    logic [CNT_W-1:0]      reserved;            // words with a byte issued but not yet pushed
    logic [RD_LATENCY:0]   vld_pipe;            // [0] = mem_addr valid this cycle
    logic [RD_LATENCY:0]   lst_pipe;            // tags the burst's final byte
    logic [WORD_BYTES-1:0][MEM_WIDTH-1:0] pk_data;
    logic [LANE_W-1:0]     pk_lane;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full, fifo_empty;
    logic [SUM_W-1:0]      credit_sum;
    word_t                 word_in, word_out;

    logic issue_nxt, start, done_nxt, take_rsv;
    logic credit_ok, push, pop, pop_last;

    assign req_ready  = (state == IDLE);
    assign credit_sum = {1'b0, fifo_count} + {1'b0, reserved};
    assign credit_ok  = !fifo_full && (credit_sum < SUM_W'(FIFO_DEPTH));
    assign take_rsv   = issue_nxt && (start || (iss_lane == '0));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and issue decision; only a word's first byte waits for credit.
    always_comb begin
        state_nxt = state;
        issue_nxt = 1'b0;
        start     = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_len == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        start     = 1'b1;
                        issue_nxt = 1'b1;
                        state_nxt = FETCH;
                    end
                end
            end
            FETCH: begin
                if (lst_pipe[0])                          state_nxt = DRAIN;
                else if ((iss_lane != '0) || credit_ok)   issue_nxt = 1'b1;
            end
            DRAIN: begin
                if (pop_last && !(|vld_pipe)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Remaining-byte count after the byte about to be presented.
    always_comb begin
        rem_nxt = rem;
        if (start)          rem_nxt = req_len - LEN_WIDTH'(1);
        else if (issue_nxt) rem_nxt = rem - LEN_WIDTH'(1);
    end

    // Address generator, tag pipe, reservation counter and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr <= '0;
            rem      <= '0;
            iss_lane <= '0;
            reserved <= '0;
            vld_pipe <= '0;
            lst_pipe <= '0;
            done     <= 1'b0;
        end else begin
            rem      <= rem_nxt;
            done     <= done_nxt;
            vld_pipe <= {vld_pipe[RD_LATENCY-1:0], issue_nxt};
            lst_pipe <= {lst_pipe[RD_LATENCY-1:0], issue_nxt && (rem_nxt == '0)};
            reserved <= reserved + CNT_W'(take_rsv) - CNT_W'(push);
            if (start) begin
                mem_addr <= req_addr;
                iss_lane <= (WORD_BYTES == 1) ? '0 : LANE_W'(1);
            end else if (issue_nxt) begin
                mem_addr <= (mem_addr == ADDR_MAX) ? '0 : mem_addr + ADDR_WIDTH'(1);
                iss_lane <= (iss_lane == LAST_LANE) ? '0 : iss_lane + LANE_W'(1);
            end
        end
    end

    // Word assembled from the packer plus the byte arriving this cycle.
    always_comb begin
        word_in.data          = pk_data;
        word_in.data[pk_lane] = mem_data;
        for (int i = 0; i < WORD_BYTES; i++) word_in.keep[i] = (i <= int'(pk_lane));
        word_in.last          = lst_pipe[RD_LATENCY];
        push = vld_pipe[RD_LATENCY] && ((pk_lane == LAST_LANE) || lst_pipe[RD_LATENCY]);
    end

    // Packer: collect tagged bytes, clear after each push so unused lanes read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pk_data <= '0;
            pk_lane <= '0;
        end else if (vld_pipe[RD_LATENCY]) begin
            if (push) begin
                pk_data <= '0;
                pk_lane <= '0;
            end else begin
                pk_data[pk_lane] <= mem_data;
                pk_lane          <= pk_lane + LANE_W'(1);
            end
        end
    end

    dram_rd_fifo #(
        .WIDTH ($bits(word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (word_in),
        .pop   (pop),
        .dout  (word_out),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign pop_last  = pop && word_out.last;
    assign out_data  = out_valid ? word_out.data : '0;
    assign out_keep  = out_valid ? word_out.keep : '0;
    assign out_last  = out_valid && word_out.last;

endmodule

// File: tb/tb_dram_burst_reader.sv
// Directed bench for dram_burst_reader with a byte[i] = i[7:0] DRAM model.
module tb_dram_burst_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [23:0] req_addr = '0;
    logic [15:0] req_len = '0;
    logic [23:0] mem_addr;
    logic [7:0]  mem_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        done;

    int errs = 0;
    int checks = 0;

    typedef struct {
        logic [23:0] addr;
        logic [15:0] len;
        int          n;
        int          first;
        logic [23:0] a3;
        logic [31:0] d0;
        logic [3:0]  k0;
        logic [31:0] d1;
        logic [3:0]  k1;
    } vec_t;

    vec_t vecs [7];

    dram_burst_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    // DRAM model: one-cycle registered read, contents equal to the low address byte.
    always @(posedge clk) mem_data <= mem_addr[7:0];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int nw;
        int cyc;
        int first;
        logic [31:0] ed;
        logic [3:0]  ek;
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_len   = v.len;
        step();
        req_valid = 1'b0;
        chk({tag, "_issue_addr"}, 32'(mem_addr), 32'(v.addr));
        nw = 0;
        cyc = 1;
        first = -1;
        while (nw < v.n && cyc < 100) begin
            if (cyc == 4) chk({tag, "_addr_c4"}, 32'(mem_addr), 32'(v.a3));
            if (out_valid && first < 0) first = cyc;
            if (out_valid && out_ready) begin
                ed = (nw == 0) ? v.d0 : v.d1;
                ek = (nw == 0) ? v.k0 : v.k1;
                chk($sformatf("%s_w%0d_data", tag, nw), out_data, ed);
                chk($sformatf("%s_w%0d_keep", tag, nw), 32'(out_keep), 32'(ek));
                chk($sformatf("%s_w%0d_last", tag, nw), 32'(out_last), 32'(nw == v.n - 1));
                nw++;
            end
            step();
            cyc++;
        end
        if (nw < v.n) begin
            checks++;
            errs++;
            $display("FAIL %s_timeout: got %0d words expected %0d", tag, nw, v.n);
        end
        chk({tag, "_first_valid"}, 32'(first), 32'(v.first));
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        step();
        chk({tag, "_done_fall"}, 32'(done), 32'd0);
    endtask

    initial begin
        int k;
        int cyc;
        logic ov_seen;
        logic [7:0] b;

        vecs[0] = '{24'h000010, 16'd8, 2, 6, 24'h000013, 32'h13121110, 4'hF, 32'h17161514, 4'hF};
        vecs[1] = '{24'h000003, 16'd5, 2, 6, 24'h000006, 32'h06050403, 4'hF, 32'h00000007, 4'h1};
        vecs[2] = '{24'h1FFFFE, 16'd4, 1, 6, 24'h000001, 32'h0100FFFE, 4'hF, 32'h0, 4'h0};
        vecs[3] = '{24'h000020, 16'd2, 1, 4, 24'h000021, 32'h00002120, 4'h3, 32'h0, 4'h0};
        vecs[4] = '{24'h1FFFFD, 16'd6, 2, 6, 24'h000000, 32'h00FFFEFD, 4'hF, 32'h00000201, 4'h3};
        vecs[5] = '{24'h000040, 16'd7, 2, 6, 24'h000043, 32'h43424140, 4'hF, 32'h00464544, 4'h7};
        vecs[6] = '{24'h000055, 16'd3, 1, 5, 24'h000057, 32'h00575655, 4'h7, 32'h0, 4'h0};

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_bits", {out_data[27:0], out_keep}, 32'd0);
        chk("rst_last_done", {30'd0, out_last, done}, 32'd0);
        rst_n = 1'b1;
        step();

        // zero length: done next cycle, no output, address untouched
        req_valid = 1'b1;
        req_addr  = 24'h000123;
        req_len   = 16'd0;
        step();
        req_valid = 1'b0;
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_req_ready", 32'(req_ready), 32'd1);
        chk("zero_mem_addr", 32'(mem_addr), 32'd0);
        ov_seen = out_valid;
        step();
        chk("zero_done_fall", 32'(done), 32'd0);
        for (int i = 0; i < 5; i++) begin
            ov_seen = ov_seen | out_valid;
            step();
        end
        chk("zero_no_output", 32'(ov_seen), 32'd0);

        // table of directed bursts
        for (int i = 0; i < 7; i++) run_vec($sformatf("v%0d", i), vecs[i]);

        // backpressure: 32 bytes, consumer stalled for 20 cycles
        out_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 24'h000100;
        req_len   = 16'd32;
        step();
        req_valid = 1'b0;
        repeat (19) step();
        chk("bp_addr_stalled", 32'(mem_addr), 32'h10F);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        k = 0;
        cyc = 0;
        while (k < 8 && cyc < 300) begin
            if (out_valid) begin
                b = 8'(k * 4);
                chk($sformatf("bp_w%0d_data", k), out_data, {b + 8'd3, b + 8'd2, b + 8'd1, b});
                chk($sformatf("bp_w%0d_keep_last", k), {27'd0, out_keep, out_last}, {27'd0, 4'hF, k == 7});
                k++;
            end
            step();
            cyc++;
        end
        if (k < 8) begin
            checks++;
            errs++;
            $display("FAIL bp_timeout: got %0d words expected 8", k);
        end
        chk("bp_done", 32'(done), 32'd1);
        step();

        // reset in the middle of a burst with a word waiting
        out_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 24'h000200;
        req_len   = 16'd16;
        step();
        req_valid = 1'b0;
        repeat (7) step();
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_bits", {out_data[27:0], out_keep}, 32'd0);
        chk("mid_rst_last_done_ready", {29'd0, out_last, done, req_ready}, 32'd1);
        step();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        run_vec("post_rst", '{24'h000300, 16'd4, 1, 6, 24'h000303, 32'h03020100, 4'hF, 32'h0, 4'h0});
        ov_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ov_seen = ov_seen | out_valid | done;
            step();
        end
        chk("post_rst_quiet", 32'(ov_seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/dram_burst_reader.md
# dram_burst_reader

Read initiator for the byte-wide DRAM model: accepts a burst request (start address, byte count), drives the DRAM `addr` port one byte per cycle, captures `data_out` after the fixed read latency, and packs bytes little-endian into words for a valid/ready consumer. It sits between the DRAM and any block that needs bulk data, such as a loader, DMA or checksum engine, and throttles address issue so a stalled consumer never loses data. The DRAM has no enable, so flow control is by credit.

## Interface
- `ADDR_WIDTH`, 24: DRAM address width.
- `MEM_DEPTH`, 2097152: DRAM size in bytes; addresses wrap at this value.
- `MEM_WIDTH`, 8: DRAM data width.
- `WORD_BYTES`, 4: bytes packed per output word.
- `LEN_WIDTH`, 16: width of the burst length field.
- `RD_LATENCY`, 1: cycles from `mem_addr` to valid `mem_data`.
- `FIFO_DEPTH`, 4: output FIFO depth in words; must be a power of 2 and at least 2.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  burst request valid.
- `req_ready`  out  1  equals `state==IDLE`.
- `req_addr`  in  ADDR_WIDTH  start byte address; must be less than MEM_DEPTH.
- `req_len`  in  LEN_WIDTH  byte count; 0 is legal.
- `mem_addr`  out  ADDR_WIDTH  to DRAM `addr`.
- `mem_data`  in  MEM_WIDTH  from DRAM `data_out`.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  consumer accept.
- `out_data`  out  MEM_WIDTH*WORD_BYTES  packed word; byte 0 is in bits [7:0].
- `out_keep`  out  WORD_BYTES  valid-byte mask.
- `out_last`  out  1  final word of the burst.
- `done`  out  1  one-cycle pulse at burst completion.

## Operation
- FSM states are IDLE, FETCH and DRAIN.
- **IDLE:** on `req_valid`, latch `req_addr` and `req_len`.
  - If `req_len==0`, pulse `done` on the next cycle, stay in IDLE, produce no output.
  - Otherwise go to FETCH.
- **FETCH:** issue one address per cycle while a word credit is available.
  - Credit rule: `fifo_count + reserved < FIFO_DEPTH`.
  - A reservation is taken when the first byte of a word is issued and released when that word is pushed into the FIFO.
  - Issue proceeds without a credit check for the rest of a word once its first byte has issued.
  - When no credit is available, `mem_addr` holds its value and no byte is tagged valid.
  - After the last byte issues, go to DRAIN.
- **Capture:** a valid-tag shift register of length RD_LATENCY tracks issued bytes.
  - A tagged byte is written into the packer at lane `byte_idx`.
  - The packer pushes to the FIFO when the lane reaches WORD_BYTES-1 or when the burst's final byte arrives.
- **Partial final word:**
  - `out_keep` has its low `((req_len-1) % WORD_BYTES)+1` bits set.
  - Unused lanes read as 0.
  - `out_last` is set.
  - All earlier words have `out_keep` all ones and `out_last` 0.
- **DRAIN:** wait until no tags are in flight and the last word has been accepted (`out_valid && out_ready` with `out_last`). Then pulse `done` and go to IDLE.
- **Address arithmetic:** next = (cur == MEM_DEPTH-1) ? 0 : cur+1. The wrap is silent and the burst continues.
- **Reset while active:** asynchronous reset discards the FIFO, packer, tags and reservations. No partial word or `done` is emitted afterwards.

## Timing
- **Reset values:**
  - state IDLE, so `req_ready`=1 while `rst_n` is low.
  - `mem_addr`=0.
  - `out_valid`=0, `out_last`=0, `out_keep`=0, `out_data`=0.
  - `done`=0.
  - All counters 0.
- **Address issue:** request accepted at edge T; `mem_addr` = `req_addr` in cycle T+1; one address per cycle while credit is available.
- **Data capture:** the byte for an address presented in cycle N is sampled at the edge ending cycle N+RD_LATENCY.
- **First word:** `out_valid` rises in cycle T+1+WORD_BYTES+RD_LATENCY. This is T+6 at defaults.
- **Throughput:** 1 byte per cycle when unstalled.
- **Output handshake:**
  - `out_data`, `out_keep` and `out_last` are stable while `out_valid` is high and `out_ready` is low.
  - The FIFO supports a push and a pop in the same cycle.
- **`done` timing:** `done` asserts in the cycle after the final handshake, which is also the first cycle `req_ready` returns to 1.

## Structure
- **Package `dram_rd_pkg`:**
  - State enum {IDLE, FETCH, DRAIN}.
  - Default constants for ADDR_WIDTH, MEM_DEPTH, MEM_WIDTH and WORD_BYTES.
- **Sub-module `dram_rd_fifo`:** parameterised synchronous FIFO.
  - Payload width `WORD_BYTES*MEM_WIDTH + WORD_BYTES + 1`.
  - Exposes `count`, `full` and `empty`.
- **Top level:** FSM, address generator, tag pipe, packer and credit logic.

## Test plan
- **Basic burst:** DRAM preloaded so byte[i] = i[7:0]; request addr 0x000010, len 8, `out_ready`=1.
  - Expect 2 words: 0x13121110 with keep 0xF, then 0x17161514 with keep 0xF and last=1.
  - First `out_valid` at T+6; `done` one cycle after the second handshake.
- **Partial word:** request addr 0x000003, len 5.
  - Word 0x06050403 with keep 0xF, then 0x00000007 with keep 0x1 and last=1.
- **Wrap:** request addr 0x1FFFFE, len 4.
  - `mem_addr` sequence is 0x1FFFFE, 0x1FFFFF, 0x000000, 0x000001.
  - Output word 0x0100FFFE.
- **Backpressure:** len 32, `out_ready` held at 0 for 20 cycles.
  - At most FIFO_DEPTH words are buffered and `mem_addr` stalls.
  - After release, all 8 words arrive in order with no byte lost or duplicated.
- **Zero length:** `req_len`=0.
  - `done` pulses on the next cycle, `out_valid` never rises, `mem_addr` is unchanged.
- **Reset mid-burst:** len 16, assert `rst_n`=0 during FETCH.
  - All outputs take their reset values asynchronously.
  - A fresh len 4 request afterwards produces exactly one correct word.
